// File: rtl/operand_sequencer.sv
// Sequences register reads, ALU operand delivery and write-back for one decoded instruction at a time.
// Latency R+E+Wr+1 cycles from accept to done; instr_ready is low from accept until the cycle after done.
module operand_sequencer #(
   parameter int W           = 8,
   parameter int SEL_W       = 4,
   parameter int READ_CYCLES = 1,
   parameter int ALU_LAT     = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [5:0]       flags,
   input  logic [W-1:0]     i1,
   input  logic [W-1:0]     i2,
   input  logic [W-1:0]     i3,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic [W-1:0]     result,
   output logic [W-1:0]     a,
   output logic [W-1:0]     b,
   output logic [W-1:0]     z,
   output logic [SEL_W-1:0] x_sel,
   output logic [SEL_W-1:0] y_sel,
   output logic [SEL_W-1:0] z_sel,
   output logic             x_enb,
   output logic             y_enb,
   output logic             z_enb,
   output logic             done,
   output logic             err
);

   localparam int CNT_MAX = (READ_CYCLES > ALU_LAT) ? READ_CYCLES : ALU_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, FIN} state_t;

   state_t           state, nxt;
   logic [5:0]       flags_q, f;
   logic [W-1:0]     i2_q, i3_q, i2v, i3v;
   logic [W-1:0]     a_d, b_d, z_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [1:0]       zsrc;
   logic             acc, rd, ex, wr, last;
   logic             unused_i1_hi;

   // Only the low SEL_W bits of i1 matter (destination select).
   assign unused_i1_hi = ^i1;

   assign instr_ready = (state == IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      acc   = instr_valid & (state == IDLE);
      // On the accept edge the latched copies are not loaded yet, so decode the live inputs.
      f     = acc ? flags : flags_q;
      i2v   = acc ? i2 : i2_q;
      i3v   = acc ? i3 : i3_q;
      zsrc  = f[5:4];
      rd    = f[1] | f[0];
      ex    = f[2] & (zsrc == 2'b11);
      wr    = f[2] & (zsrc != 2'b00);
      last  = (cnt == '0);
      nxt   = state;
      cnt_d = cnt;
      a_d   = a;
      b_d   = b;
      z_d   = z;
      case (state)
         IDLE: begin
            if (acc) begin
               if (rd)      nxt = READ;
               else if (ex) nxt = EXEC;
               else if (wr) nxt = WRITE;
               else         nxt = FIN;
               if (!rd) begin
                  a_d = '0;
                  b_d = f[3] ? '0 : i3v;
               end
            end
         end
         READ: begin
            cnt_d = cnt - CNT_W'(1);
            if (last) begin
               if (ex)      nxt = EXEC;
               else if (wr) nxt = WRITE;
               else         nxt = FIN;
               a_d = f[1] ? x : '0;
               b_d = f[3] ? y : i3v;
            end
         end
         EXEC: begin
            cnt_d = cnt - CNT_W'(1);
            if (last) begin
               nxt = WRITE;
               z_d = result;
            end
         end
         WRITE:   nxt = FIN;
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (nxt == READ && state != READ) cnt_d = CNT_W'(READ_CYCLES - 1);
      if (nxt == EXEC && state != EXEC) cnt_d = CNT_W'(ALU_LAT - 1);
      // a_d, not a: a move from x must see the operand captured on this same edge.
      if (nxt == WRITE && state != WRITE) begin
         if (zsrc == 2'b01)      z_d = i2v;
         else if (zsrc == 2'b10) z_d = a_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= '0;
         i2_q    <= '0;
         i3_q    <= '0;
         cnt     <= '0;
         a       <= '0;
         b       <= '0;
         z       <= '0;
         x_sel   <= '0;
         y_sel   <= '0;
         z_sel   <= '0;
         x_enb   <= 1'b0;
         y_enb   <= 1'b0;
         z_enb   <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (acc) begin
            flags_q <= flags;
            i2_q    <= i2;
            i3_q    <= i3;
            x_sel   <= i2[SEL_W-1:0];
            y_sel   <= i3[SEL_W-1:0];
            z_sel   <= i1[SEL_W-1:0];
         end
         cnt   <= cnt_d;
         a     <= a_d;
         b     <= b_d;
         z     <= z_d;
         x_enb <= (nxt == READ) & f[1];
         y_enb <= (nxt == READ) & f[0];
         z_enb <= (nxt == WRITE);
         done  <= (nxt == FIN);
         err   <= (nxt == FIN) & f[2] & (zsrc == 2'b00);
      end
   end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: default instance plus a READ_CYCLES=3 / ALU_LAT=2 instance.
module tb_operand_sequencer;

   logic       clk;
   logic       reset_n;
   logic [1:0] instr_valid;
   logic [5:0] flags;
   logic [7:0] i1, i2, i3, x, y, result;

   logic       ready_o [2];
   logic [7:0] a_o     [2];
   logic [7:0] b_o     [2];
   logic [7:0] z_o     [2];
   logic [3:0] xs_o    [2];
   logic [3:0] ys_o    [2];
   logic [3:0] zs_o    [2];
   logic       xe_o    [2];
   logic       ye_o    [2];
   logic       ze_o    [2];
   logic       done_o  [2];
   logic       err_o   [2];

   int tests = 0;
   int fails = 0;
   int rc [2] = '{1, 3};
   int al [2] = '{1, 2};
   logic [7:0] pa [2];
   logic [7:0] pb [2];
   logic [7:0] pz [2];

   operand_sequencer u0 (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid[0]), .instr_ready(ready_o[0]),
      .flags(flags), .i1(i1), .i2(i2), .i3(i3), .x(x), .y(y), .result(result),
      .a(a_o[0]), .b(b_o[0]), .z(z_o[0]), .x_sel(xs_o[0]), .y_sel(ys_o[0]), .z_sel(zs_o[0]),
      .x_enb(xe_o[0]), .y_enb(ye_o[0]), .z_enb(ze_o[0]), .done(done_o[0]), .err(err_o[0])
   );

   operand_sequencer #(.READ_CYCLES(3), .ALU_LAT(2)) u1 (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid[1]), .instr_ready(ready_o[1]),
      .flags(flags), .i1(i1), .i2(i2), .i3(i3), .x(x), .y(y), .result(result),
      .a(a_o[1]), .b(b_o[1]), .z(z_o[1]), .x_sel(xs_o[1]), .y_sel(ys_o[1]), .z_sel(zs_o[1]),
      .x_enb(xe_o[1]), .y_enb(ye_o[1]), .z_enb(ze_o[1]), .done(done_o[1]), .err(err_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input int d);
      check("rst_ready", 16'(ready_o[d]), 16'd1);
      check("rst_strobes", 16'({xe_o[d], ye_o[d], ze_o[d], done_o[d], err_o[d]}), 16'd0);
      check("rst_abz", 16'({a_o[d], b_o[d]}) | 16'(z_o[d]), 16'd0);
      check("rst_sels", 16'({xs_o[d], ys_o[d], zs_o[d]}), 16'd0);
      pa[d] = 8'h00;
      pb[d] = 8'h00;
      pz[d] = 8'h00;
   endtask

   // Starts just after a falling edge in an idle cycle; returns at the falling edge of the first idle cycle after done.
   task automatic run(input int d, input logic [5:0] fl, input logic [7:0] v1, v2, v3,
                      input logic [7:0] xv, yv, rv, input bit rnd, input bit hold);
      logic [7:0] xh [16];
      logic [7:0] yh [16];
      logic [7:0] rh [16];
      logic [7:0] ea, eb, ez;
      logic [1:0] zs;
      bit xrd, yrd, bsel, wen, exa, wra;
      int r, e, w, lat;
      zs   = fl[5:4];
      bsel = fl[3];
      wen  = fl[2];
      xrd  = fl[1];
      yrd  = fl[0];
      exa  = wen && (zs == 2'b11);
      wra  = wen && (zs != 2'b00);
      r    = (xrd || yrd) ? rc[d] : 0;
      e    = exa ? al[d] : 0;
      w    = wra ? 1 : 0;
      lat  = r + e + w + 1;
      ea   = pa[d];
      eb   = pb[d];
      ez   = pz[d];
      check("ready_before", 16'(ready_o[d]), 16'd1);
      flags = fl;
      i1 = v1;
      i2 = v2;
      i3 = v3;
      instr_valid[d] = 1'b1;
      @(posedge clk);
      #1;
      instr_valid[d] = hold;
      flags = 6'($urandom);
      i1 = 8'($urandom);
      i2 = 8'($urandom);
      i3 = 8'($urandom);
      for (int k = 1; k <= lat + 1; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         x      = rnd ? 8'($urandom) : xv;
         y      = rnd ? 8'($urandom) : yv;
         result = rnd ? 8'($urandom) : rv;
         xh[k] = x;
         yh[k] = y;
         rh[k] = result;
         @(negedge clk);
         ea = pa[d];
         eb = pb[d];
         ez = pz[d];
         if (k > r) begin
            ea = (r > 0 && xrd) ? xh[r] : 8'h00;
            eb = bsel ? ((r > 0) ? yh[r] : 8'h00) : v3;
         end
         if (wra && k > r + e)
            ez = (zs == 2'b01) ? v2 : (zs == 2'b10) ? ea : rh[r + e];
         check("ready", 16'(ready_o[d]), 16'(k > lat));
         check("x_enb", 16'(xe_o[d]), 16'(k <= r && xrd));
         check("y_enb", 16'(ye_o[d]), 16'(k <= r && yrd));
         check("z_enb", 16'(ze_o[d]), 16'(wra && k == r + e + 1));
         check("done", 16'(done_o[d]), 16'(k == lat));
         check("err", 16'(err_o[d]), 16'(k == lat && wen && zs == 2'b00));
         check("a", 16'(a_o[d]), 16'(ea));
         check("b", 16'(b_o[d]), 16'(eb));
         check("z", 16'(z_o[d]), 16'(ez));
         if (k == lat) check("sels", 16'({xs_o[d], ys_o[d], zs_o[d]}), 16'({v2[3:0], v3[3:0], v1[3:0]}));
      end
      pa[d] = ea;
      pb[d] = eb;
      pz[d] = ez;
   endtask

   initial begin
      reset_n = 1'b0;
      instr_valid = 2'b00;
      flags = 6'd0;
      i1 = 8'd0;
      i2 = 8'd0;
      i3 = 8'd0;
      x = 8'd0;
      y = 8'd0;
      result = 8'd0;
      repeat (2) @(negedge clk);
      check_reset(0);
      check_reset(1);
      reset_n = 1'b1;
      @(negedge clk);

      // ALU op with defaults, immediate load, error and no-write cases.
      run(0, 6'b111111, 8'd3, 8'd5, 8'd6, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
      run(0, 6'b010100, 8'd7, 8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
      run(0, 6'b000100, 8'd1, 8'd2, 8'd3, 8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
      run(0, 6'b110000, 8'd1, 8'd2, 8'd3, 8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
      // Move x with immediate b on the slow instance.
      run(1, 6'b100110, 8'd2, 8'd4, 8'h09, 8'h4C, 8'h77, 8'h88, 1'b0, 1'b0);
      run(1, 6'b111111, 8'd9, 8'd10, 8'd11, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      // Back-to-back with instr_valid held high and scrambled data while busy.
      run(0, 6'b111111, 8'd1, 8'd2, 8'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      run(0, 6'b010100, 8'd4, 8'h5A, 8'd6, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      run(0, 6'b101110, 8'd7, 8'd8, 8'd9, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

      // Reset in the middle of a multi-cycle READ.
      flags = 6'b000011;
      i1 = 8'd5;
      i2 = 8'd6;
      i3 = 8'd7;
      instr_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      instr_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      check("mid_read_x_enb", 16'(xe_o[1]), 16'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset(1);
      check_reset(0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 40; n++)
         run(n % 2, 6'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
